// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between two L1 requesters.
// One block transaction is in flight at a time; the response goes to the granted port only.
module l2_port_arbiter #(
   parameter int ADDR_WIDTH    = 11,
   parameter int DATA_WIDTH    = 8,
   parameter int L1_BLOCK_SIZE = 16,
   parameter int BW            = L1_BLOCK_SIZE * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic                  req0_read,
   input  logic                  req0_write,
   input  logic [BW-1:0]         req0_wdata,
   output logic [BW-1:0]         req0_rdata,
   output logic                  req0_ready,
   output logic                  req0_hit,

   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic                  req1_read,
   input  logic                  req1_write,
   input  logic [BW-1:0]         req1_wdata,
   output logic [BW-1:0]         req1_rdata,
   output logic                  req1_ready,
   output logic                  req1_hit,

   output logic [ADDR_WIDTH-1:0] l2_addr,
   output logic                  l2_read,
   output logic                  l2_write,
   output logic [BW-1:0]         l2_wdata,
   input  logic [BW-1:0]         l2_rdata,
   input  logic                  l2_ready,
   input  logic                  l2_hit,

   output logic                  grant,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state;
   logic   last_grant;
   logic   mask_v;
   logic   mask_port;

   logic                  want0;
   logic                  want1;
   logic                  win;
   logic                  win_port;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_write;
   logic [BW-1:0]         sel_wdata;

   // The port just served is excluded for one IDLE cycle after its RESP.
   always_comb begin
      want0 = (req0_read | req0_write)
            & ~(mask_v & ~mask_port);
      want1 = (req1_read | req1_write)
            & ~(mask_v & mask_port);
      win   = want0 | want1;
      if (want0 & want1) begin
         win_port = ~last_grant;
      end else begin
         win_port = want1;
      end
   end

   // Write takes precedence when a port raises both read and write.
   always_comb begin
      if (win_port) begin
         sel_addr  = req1_addr;
         sel_write = req1_write;
         sel_wdata = req1_wdata;
      end else begin
         sel_addr  = req0_addr;
         sel_write = req0_write;
         sel_wdata = req0_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         mask_v     <= 1'b0;
         mask_port  <= 1'b0;
         l2_addr    <= '0;
         l2_read    <= 1'b0;
         l2_write   <= 1'b0;
         l2_wdata   <= '0;
         req0_rdata <= '0;
         req1_rdata <= '0;
         req0_hit   <= 1'b0;
         req1_hit   <= 1'b0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         grant      <= 1'b0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               mask_v <= 1'b0;
               if (win) begin
                  l2_addr    <= sel_addr;
                  l2_write   <= sel_write;
                  l2_read    <= ~sel_write;
                  l2_wdata   <= sel_wdata;
                  grant      <= win_port;
                  last_grant <= win_port;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (l2_ready) begin
                  if (grant) begin
                     if (l2_read) begin
                        req1_rdata <= l2_rdata;
                     end
                     req1_hit   <= l2_hit;
                     req1_ready <= 1'b1;
                  end else begin
                     if (l2_read) begin
                        req0_rdata <= l2_rdata;
                     end
                     req0_hit   <= l2_hit;
                     req0_ready <= 1'b1;
                  end
                  l2_read  <= 1'b0;
                  l2_write <= 1'b0;
                  state    <= RESP;
               end
            end
            RESP: begin
               req0_ready <= 1'b0;
               req1_ready <= 1'b0;
               busy       <= 1'b0;
               mask_v     <= 1'b1;
               mask_port  <= grant;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomised and directed bench for l2_port_arbiter against a
// transaction-level model of the arbitration and response rules.
module tb_l2_port_arbiter;

   localparam int AW = 11;
   localparam int BW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [AW-1:0] req0_addr = '0;
   logic          req0_read = 1'b0;
   logic          req0_write = 1'b0;
   logic [BW-1:0] req0_wdata = '0;
   logic [BW-1:0] req0_rdata;
   logic          req0_ready;
   logic          req0_hit;
   logic [AW-1:0] req1_addr = '0;
   logic          req1_read = 1'b0;
   logic          req1_write = 1'b0;
   logic [BW-1:0] req1_wdata = '0;
   logic [BW-1:0] req1_rdata;
   logic          req1_ready;
   logic          req1_hit;
   logic [AW-1:0] l2_addr;
   logic          l2_read;
   logic          l2_write;
   logic [BW-1:0] l2_wdata;
   logic [BW-1:0] l2_rdata = '0;
   logic          l2_ready = 1'b0;
   logic          l2_hit = 1'b0;
   logic          grant;
   logic          busy;

   l2_port_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_addr  (req0_addr),
      .req0_read  (req0_read),
      .req0_write (req0_write),
      .req0_wdata (req0_wdata),
      .req0_rdata (req0_rdata),
      .req0_ready (req0_ready),
      .req0_hit   (req0_hit),
      .req1_addr  (req1_addr),
      .req1_read  (req1_read),
      .req1_write (req1_write),
      .req1_wdata (req1_wdata),
      .req1_rdata (req1_rdata),
      .req1_ready (req1_ready),
      .req1_hit   (req1_hit),
      .l2_addr    (l2_addr),
      .l2_read    (l2_read),
      .l2_write   (l2_write),
      .l2_wdata   (l2_wdata),
      .l2_rdata   (l2_rdata),
      .l2_ready   (l2_ready),
      .l2_hit     (l2_hit),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name,
                      input logic [BW-1:0] got,
                      input logic [BW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   function automatic logic [BW-1:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // L2 responder: answers after l2_lat waiting cycles, may pulse l2_ready
   // spuriously while no request is outstanding.
   int            l2_lat = 0;
   logic [BW-1:0] l2_fill = '0;
   logic          l2_hitv = 1'b0;
   bit            spur_en = 1'b0;
   int            wcnt = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            l2_ready = 1'b0;
            wcnt = 0;
         end else if (l2_read | l2_write) begin
            if (wcnt >= l2_lat) begin
               l2_ready = 1'b1;
               l2_rdata = l2_fill;
               l2_hit   = l2_hitv;
               wcnt = 0;
            end else begin
               l2_ready = 1'b0;
               l2_rdata = rand128();
               l2_hit   = 1'($urandom % 2);
               wcnt++;
            end
         end else begin
            wcnt = 0;
            l2_ready = spur_en && ($urandom % 6 == 0);
            l2_rdata = rand128();
            l2_hit   = 1'($urandom % 2);
         end
      end
   end

   // Transaction-level model: one open transaction, its completion is
   // reported one cycle after the L2 answers, then the served port sits
   // out one arbitration.
   logic [AW-1:0] m_addr;
   logic [BW-1:0] m_wdata;
   logic          m_rd, m_wr, m_grant, m_busy, m_last;
   logic [BW-1:0] m_rdata [2];
   logic          m_hit [2];
   logic          m_rdy [2];
   bit            m_open, m_done;
   int            m_mask;

   task automatic model_reset();
      m_addr = '0; m_wdata = '0;
      m_rd = 0; m_wr = 0; m_grant = 0; m_busy = 0;
      m_last = 1;
      for (int p = 0; p < 2; p++) begin
         m_rdata[p] = '0; m_hit[p] = 0; m_rdy[p] = 0;
      end
      m_open = 0; m_done = 0; m_mask = -1;
   endtask

   task automatic model_step();
      int   nmask;
      bit   r0, r1;
      logic w;
      nmask = -1;
      m_rdy[0] = 0;
      m_rdy[1] = 0;
      if (m_done) begin
         m_done = 0; m_open = 0; m_busy = 0;
         nmask = int'(m_grant);
      end else if (m_open) begin
         if (l2_ready) begin
            if (m_rd) m_rdata[m_grant] = l2_rdata;
            m_hit[m_grant] = l2_hit;
            m_rdy[m_grant] = 1;
            m_rd = 0; m_wr = 0; m_done = 1;
         end
      end else begin
         r0 = (req0_read | req0_write) && m_mask != 0;
         r1 = (req1_read | req1_write) && m_mask != 1;
         if (r0 || r1) begin
            w = (r0 && r1) ? ~m_last : r1;
            if (w) begin
               m_addr = req1_addr; m_wr = req1_write; m_wdata = req1_wdata;
            end else begin
               m_addr = req0_addr; m_wr = req0_write; m_wdata = req0_wdata;
            end
            m_rd = ~m_wr;
            m_open = 1; m_busy = 1;
            m_grant = w; m_last = w;
         end
      end
      m_mask = nmask;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (rst_n) model_reset();
         else model_step();
         @(negedge clk);
         if (rst_n) model_reset();
         chk("l2_read", BW'(l2_read), BW'(m_rd));
         chk("l2_write", BW'(l2_write), BW'(m_wr));
         chk("l2_addr", BW'(l2_addr), BW'(m_addr));
         chk("l2_wdata", l2_wdata, m_wdata);
         chk("grant", BW'(grant), BW'(m_grant));
         chk("busy", BW'(busy), BW'(m_busy));
         chk("req0_ready", BW'(req0_ready), BW'(m_rdy[0]));
         chk("req1_ready", BW'(req1_ready), BW'(m_rdy[1]));
         chk("req0_rdata", req0_rdata, m_rdata[0]);
         chk("req1_rdata", req1_rdata, m_rdata[1]);
         chk("req0_hit", BW'(req0_hit), BW'(m_hit[0]));
         chk("req1_hit", BW'(req1_hit), BW'(m_hit[1]));
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ready(output int port);
      port = -1;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (req0_ready | req1_ready) begin
            port = req1_ready ? 1 : 0;
            return;
         end
      end
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: no ready within 60 cycles");
   endtask

   task automatic wait_l2(output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (l2_read | l2_write) begin
            ok = 1;
            return;
         end
         @(posedge clk);
         #1;
      end
      n_vec++;
      n_bad++;
      $display("FAIL l2_req_timeout: no l2 request within 40 cycles");
   endtask

   task automatic rnd_req(inout bit on, inout logic rd, inout logic wr);
      int op;
      if (!on) begin
         if ($urandom % 3 == 0) begin
            on = 1;
            op = int'($urandom % 4);
            rd = (op != 2);
            wr = (op >= 2);
         end
      end else if ($urandom % 6 == 0) begin
         on = 0;
         rd = 0;
         wr = 0;
      end
   endtask

   initial begin
      int            port;
      bit            ok;
      bit            on0, on1;
      logic [BW-1:0] old;
      logic          exp_g;

      step(3);
      chk("rst_l2_read", BW'(l2_read), '0);
      chk("rst_l2_write", BW'(l2_write), '0);
      chk("rst_l2_addr", BW'(l2_addr), '0);
      chk("rst_l2_wdata", l2_wdata, '0);
      chk("rst_grant", BW'(grant), '0);
      chk("rst_busy", BW'(busy), '0);
      chk("rst_rdata0", req0_rdata, '0);
      chk("rst_hit1", BW'(req1_hit), '0);
      rst_n = 1'b0;
      step(2);

      // single read
      l2_lat = 3;
      l2_fill = {16{8'hA5}};
      l2_hitv = 1'b1;
      req0_addr = 11'h120;
      req0_read = 1'b1;
      step(1);
      chk("t1_l2_read", BW'(l2_read), BW'(1'b1));
      chk("t1_l2_addr", BW'(l2_addr), BW'(11'h120));
      wait_ready(port);
      req0_read = 1'b0;
      chk("t1_port", BW'(port), BW'(0));
      step(1);
      chk("t1_ready_pulse", BW'(req0_ready), '0);
      chk("t1_rdata", req0_rdata, {16{8'hA5}});
      chk("t1_hit", BW'(req0_hit), BW'(1'b1));
      chk("t1_rdata1", req1_rdata, '0);
      chk("t1_hit1", BW'(req1_hit), '0);

      // reset while the L2 request is open
      l2_lat = 4;
      req0_addr = 11'h300;
      req0_read = 1'b1;
      step(2);
      wait_l2(ok);
      if (ok) begin
         #2 rst_n = 1'b1;
         #1;
         chk("rst_mid_l2_read", BW'(l2_read), '0);
         chk("rst_mid_busy", BW'(busy), '0);
         chk("rst_mid_rdy0", BW'(req0_ready), '0);
         chk("rst_mid_rdy1", BW'(req1_ready), '0);
      end
      req0_read = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      step(1);

      // simultaneous requests after reset
      l2_lat = 1;
      req0_addr = 11'h040;
      req1_addr = 11'h7F0;
      req0_read = 1'b1;
      req1_read = 1'b1;
      wait_ready(port);
      req0_read = 1'b0;
      chk("t2_first", BW'(port), BW'(0));
      wait_ready(port);
      req1_read = 1'b0;
      chk("t2_second", BW'(port), BW'(1));
      chk("t2_grant", BW'(grant), BW'(1'b1));
      step(3);

      // fairness with both ports always requesting
      req0_read = 1'b1;
      req1_read = 1'b1;
      l2_lat = 0;
      for (int k = 0; k < 6; k++) begin
         exp_g = 1'(k % 2);
         wait_ready(port);
         chk("fair_port", BW'(port), BW'(exp_g));
      end
      req0_read = 1'b0;
      req1_read = 1'b0;
      step(4);

      // read+write on one port becomes a write
      old = req1_rdata;
      l2_lat = 2;
      req1_addr = 11'h200;
      req1_wdata = {16{8'h3C}};
      req1_read = 1'b1;
      req1_write = 1'b1;
      step(1);
      wait_l2(ok);
      chk("t4_l2_write", BW'(l2_write), BW'(1'b1));
      chk("t4_l2_read", BW'(l2_read), '0);
      chk("t4_l2_wdata", l2_wdata, {16{8'h3C}});
      chk("t4_l2_addr", BW'(l2_addr), BW'(11'h200));
      wait_ready(port);
      req1_read = 1'b0;
      req1_write = 1'b0;
      chk("t4_port", BW'(port), BW'(1));
      chk("t4_rdata_kept", req1_rdata, old);
      step(4);

      // requester lingers one cycle past ready, then drops
      req0_addr = 11'h010;
      req0_read = 1'b1;
      l2_lat = 0;
      wait_ready(port);
      step(2);
      chk("t5a_no_regrant", BW'(l2_read), '0);
      req0_read = 1'b0;
      step(1);
      chk("t5a_busy", BW'(busy), '0);
      step(2);

      // requester keeps asking: regranted right after the masked cycle
      req0_read = 1'b1;
      wait_ready(port);
      step(2);
      chk("t5b_masked", BW'(l2_read), '0);
      step(1);
      chk("t5b_regrant", BW'(l2_read), BW'(1'b1));
      req0_read = 1'b0;
      wait_ready(port);
      chk("t5b_withdrawn_done", BW'(port), BW'(0));
      step(3);

      // randomised traffic
      spur_en = 1'b1;
      on0 = 0;
      on1 = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         rnd_req(on0, req0_read, req0_write);
         rnd_req(on1, req1_read, req1_write);
         req0_addr  = AW'($urandom);
         req1_addr  = AW'($urandom);
         req0_wdata = rand128();
         req1_wdata = rand128();
         l2_lat  = $urandom_range(0, 4);
         l2_fill = rand128();
         l2_hitv = 1'($urandom % 2);
      end
      req0_read = 1'b0;
      req0_write = 1'b0;
      req1_read = 1'b0;
      req1_write = 1'b0;
      step(12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Two-port round-robin arbiter that shares one L2_cache request port between two L1 requesters (I-side/D-side, or two cores).
- Sits between the L1_cache instances and the single L2_cache.
- Serialises block-granular read/write transactions, holds each grant until the L2 completes, and returns the response data and hit flag to the winning port only.
- One transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 11, byte address width
DATA_WIDTH, 8, bits per byte lane
L1_BLOCK_SIZE, 16, bytes per transferred block; block bus width BW = L1_BLOCK_SIZE*DATA_WIDTH (128)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
req0_addr  in  ADDR_WIDTH  port 0 block address
req0_read  in  1  port 0 read request (level)
req0_write  in  1  port 0 write request (level)
req0_wdata  in  BW  port 0 writeback block
req0_rdata  out  BW  port 0 returned block
req0_ready  out  1  port 0 completion, 1-cycle pulse
req0_hit  out  1  L2 hit flag for port 0's last transaction
req1_*  (same seven signals as req0_*)  port 1
l2_addr  out  ADDR_WIDTH  to L2
l2_read  out  1  to L2, level until l2_ready
l2_write  out  1  to L2, level until l2_ready
l2_wdata  out  BW  to L2
l2_rdata  in  BW  from L2
l2_ready  in  1  L2 completion pulse
l2_hit  in  1  L2 hit, valid with l2_ready
grant  out  1  port currently or last granted
busy  out  1  transaction in flight

Behaviour:
- Reset (rst_n=1, async):
  - state=IDLE; last_grant=1, so port 0 wins first.
  - All outputs 0: l2_read/l2_write/l2_addr/l2_wdata, both ready, both rdata, both hit, grant, busy.
  - Reset mid-transaction abandons the L2 request immediately; no ready pulse is issued.
- A port requests when read|write=1. If both are set, the transaction is a write and read is ignored.
- IDLE:
  - Arbitrate among requesting ports.
  - If exactly one requests, it wins.
  - If both request, the port != last_grant wins.
  - On a win, at the next edge: register addr/wdata/op into the l2_* outputs, set grant and last_grant, busy=1, go to ISSUE.
- ISSUE:
  - Hold the l2_* outputs constant; changes on the requester inputs are ignored.
  - On the cycle l2_ready=1, at that edge: capture l2_rdata into reqG_rdata (reads only; writes leave rdata unchanged), capture l2_hit into reqG_hit, drop l2_read/l2_write, go to RESP.
  - No timeout.
- RESP (1 cycle):
  - reqG_ready=1 for exactly this cycle; the other port's ready stays 0.
  - busy stays 1; next state IDLE.
- Post-RESP mask:
  - In the IDLE cycle immediately after RESP, the just-served port is masked from arbitration. This tolerates requesters that drop the request one cycle after ready.
  - The other port may still win in that cycle.
- Latency:
  - Request present in IDLE at edge N → l2_read/l2_write high from N+1.
  - l2_ready at edge M → reqG_ready high in cycle M+1.
  - Minimum request-to-ready with 1-cycle L2: 3 cycles.
- Request withdrawn during ISSUE: the transaction still completes and the ready pulse is still issued.
- Starvation bound: a continuously requesting port is granted within one transaction of the other port.
- reqX_rdata and reqX_hit hold their values until that port's next completed transaction.
- l2_ready seen in IDLE or RESP is ignored.

Test Plan:
- Single read: port 0 reads 0x120, L2 returns 0xA5 repeated with hit=1 after 4 cycles → l2_read high from cycle 1 to the ready edge; req0_ready pulses 1 cycle; req0_rdata=0xA5..A5; req0_hit=1; port 1 outputs stay 0.
- Simultaneous after reset: both ports read (0x040, 0x7F0) → port 0 served first, then port 1; exactly one ready per port; grant sequence 0,1.
- Fairness: both ports hold requests through 6 transactions → grants alternate 0,1,0,1,0,1; no port is served twice consecutively.
- Write priority: port 1 with read=1, write=1, addr 0x200, wdata 0x3C.. → l2_write=1, l2_read=0, l2_wdata=0x3C..; req1_rdata unchanged after ready.
- Post-RESP mask: port 0 holds its request one cycle past ready while port 1 is idle → no second L2 transaction starts in the mask cycle; a new grant to port 0 occurs the following cycle only if its request is still high.
- Reset mid-ISSUE: assert rst_n=1 while l2_read=1 → l2_read, busy, and both ready outputs go 0 asynchronously; after release, port 0 wins the first arbitration.
